// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bundle of the PS/2 receiver: show-ahead byte stream with
// valid/ready handshake plus the status pulses and FIFO occupancy.
interface ps2_rx_fifo_if #(
  parameter int FIFO_AW = 3
) ();
  logic [7:0]       scan_data;
  logic             scan_data_valid;
  logic             scan_data_ready;
  logic             frame_error;
  logic             timeout;
  logic             overflow;
  logic [FIFO_AW:0] fifo_count;

  modport master (
    output scan_data,
    output scan_data_valid,
    input  scan_data_ready,
    output frame_error,
    output timeout,
    output overflow,
    output fifo_count
  );

  modport slave (
    input  scan_data,
    input  scan_data_valid,
    output scan_data_ready,
    input  frame_error,
    input  timeout,
    input  overflow,
    input  fifo_count
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronised and glitch-filtered clock line,
// 11-bit frame capture with start/parity/stop checks, inactivity timeout, output FIFO.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 262144,
  parameter int FIFO_AW        = 3,
  parameter int CHECK_PARITY   = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_rx_fifo_if.master  rx
);

  localparam int                 DEPTH      = 1 << FIFO_AW;
  localparam int                 TW         = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]      TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]      TIMER_ONE  = TW'(1);
  localparam logic [7:0]         FILT_LAST  = 8'(FILTER_LEN - 1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   CNT_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   CNT_ZERO   = (FIFO_AW + 1)'(0);
  localparam logic [FIFO_AW:0]   CNT_FULL   = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Frame layout (bit 0 first on the wire): start, 8 data bits, parity, stop.
  function automatic logic odd_parity_ok(input logic [8:0] data_and_parity);
    return ^data_and_parity;
  endfunction

  function automatic logic frame_ok(input logic [10:0] frame);
    logic parity_ok;
    parity_ok = (CHECK_PARITY == 0) ? 1'b1 : odd_parity_ok(frame[9:1]);
    return (frame[0] == 1'b0) && (frame[10] == 1'b1) && parity_ok;
  endfunction

  logic                clk_meta_r;
  logic                clk_sync_r;
  logic                data_meta_r;
  logic                data_sync_r;
  logic                fclk_r;
  logic [7:0]          filt_cnt_r;
  logic                fall_s;

  state_t              state_r;
  logic [3:0]          bit_cnt_r;
  logic [10:0]         shift_r;
  logic [10:0]         shift_next_s;
  logic [TW-1:0]       timer_r;
  logic                good_r;
  logic                frame_error_r;
  logic                timeout_r;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_r;
  logic [FIFO_AW-1:0]  rd_ptr_r;
  logic [FIFO_AW-1:0]  rd_next_s;
  logic [FIFO_AW:0]    count_r;
  logic [FIFO_AW:0]    count_next_s;
  logic [7:0]          head_r;
  logic [7:0]          head_next_s;
  logic                valid_r;
  logic                full_s;
  logic                pop_s;
  logic                push_s;
  logic                overflow_s;

  // Two-flop synchronisers; idle line level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Clock-line filter: follow the synchronised level only after it has disagreed for FILTER_LEN cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      fclk_r     <= 1'b1;
      filt_cnt_r <= 8'd0;
    end else if (clk_sync_r != fclk_r) begin
      if (filt_cnt_r == FILT_LAST) begin
        fclk_r     <= clk_sync_r;
        filt_cnt_r <= 8'd0;
      end else begin
        fclk_r     <= fclk_r;
        filt_cnt_r <= filt_cnt_r + 8'd1;
      end
    end else begin
      fclk_r     <= fclk_r;
      filt_cnt_r <= 8'd0;
    end
  end

  // The edge is acted on in the same cycle the filter commits fclk from 1 to 0.
  assign fall_s       = fclk_r && !clk_sync_r && (filt_cnt_r == FILT_LAST);
  assign shift_next_s = {data_sync_r, shift_r[10:1]};

  // Frame FSM with timer; the verdict is registered on the stop-bit edge so CHECK sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      bit_cnt_r     <= 4'd0;
      shift_r       <= 11'd0;
      timer_r       <= {TW{1'b0}};
      good_r        <= 1'b0;
      frame_error_r <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      frame_error_r <= 1'b0;
      timeout_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          timer_r <= {TW{1'b0}};
          if (fall_s) begin
            shift_r   <= {data_sync_r, 10'd0};
            bit_cnt_r <= 4'd1;
            state_r   <= RECV;
          end else begin
            bit_cnt_r <= 4'd0;
          end
        end
        RECV: begin
          // A falling edge in the expiry cycle takes priority over the timeout.
          if (fall_s) begin
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_r + 4'd1;
            timer_r   <= {TW{1'b0}};
            if (bit_cnt_r == 4'd10) begin
              state_r       <= CHECK;
              good_r        <= frame_ok(shift_next_s);
              frame_error_r <= !frame_ok(shift_next_s);
            end else begin
              state_r <= RECV;
            end
          end else if (timer_r == TIMER_LAST) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 11'd0;
            timer_r   <= {TW{1'b0}};
            timeout_r <= 1'b1;
          end else begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        CHECK: begin
          state_r   <= IDLE;
          bit_cnt_r <= 4'd0;
          timer_r   <= {TW{1'b0}};
        end
        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= 4'd0;
          shift_r   <= 11'd0;
          timer_r   <= {TW{1'b0}};
        end
      endcase
    end
  end

  assign full_s     = (count_r == CNT_FULL);
  assign pop_s      = valid_r && rx.scan_data_ready;
  assign push_s     = (state_r == CHECK) && good_r && (!full_s || pop_s);
  assign overflow_s = !reset && (state_r == CHECK) && good_r && full_s && !pop_s;
  assign rd_next_s  = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Next show-ahead byte; the freshly pushed byte is forwarded when it becomes the head.
  always_comb begin
    head_next_s = 8'h00;
    if (count_next_s == CNT_ZERO) begin
      head_next_s = 8'h00;
    end else if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = shift_r[8:1];
    end else begin
      head_next_s = mem[rd_next_s];
    end
  end

  // Storage array; no reset needed since every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem[wr_ptr_r] <= shift_r[8:1];
    end
  end

  // Pointers, occupancy and registered head/valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      count_r  <= CNT_ZERO;
      head_r   <= 8'h00;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
      valid_r  <= (count_next_s != CNT_ZERO);
    end
  end

  assign rx.scan_data       = head_r;
  assign rx.scan_data_valid = valid_r;
  assign rx.fifo_count      = count_r;
  assign rx.frame_error     = frame_error_r;
  assign rx.timeout         = timeout_r;
  assign rx.overflow        = overflow_s;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: scenario tasks with random payloads
// checked against a queue-based model of frame acceptance and FIFO delivery.
module tb_ps2_rx_fifo;
  localparam int L    = 4;
  localparam int TOUT = 200;
  localparam int AW   = 3;
  localparam int DEP  = 8;
  localparam int HALF = 20;
  localparam int GAP  = 20;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  int total = 0;
  int bad   = 0;
  int n_ferr = 0, n_tout = 0, n_ovf = 0, stab_viol = 0;
  logic [7:0] q2[$];
  logic [7:0] model[$];
  logic [7:0] got[$];
  logic       hs_hold = 1'b0;
  logic [7:0] hs_data = 8'h00;

  always #5 clk = ~clk;

  ps2_rx_fifo_if #(.FIFO_AW(AW)) bus ();
  ps2_rx_fifo_if #(.FIFO_AW(AW)) bus2 ();

  assign bus2.scan_data_ready = 1'b1;

  ps2_rx_fifo #(.FILTER_LEN(L), .TIMEOUT_CYCLES(TOUT), .FIFO_AW(AW), .CHECK_PARITY(1)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx(bus));

  ps2_rx_fifo #(.FILTER_LEN(L), .TIMEOUT_CYCLES(TOUT), .FIFO_AW(AW), .CHECK_PARITY(0)) dut_np (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rx(bus2));

  // Pulse counters, the no-parity instance's delivered bytes, and handshake stability.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_error) n_ferr++;
      if (bus.timeout)     n_tout++;
      if (bus.overflow)    n_ovf++;
      if (bus2.scan_data_valid) q2.push_back(bus2.scan_data);
      if (hs_hold && (bus.scan_data_valid !== 1'b1 || bus.scan_data !== hs_data)) stab_viol++;
    end
  end

  always @(posedge clk) begin
    hs_hold <= bus.scan_data_valid && !bus.scan_data_ready && !reset;
    hs_data <= bus.scan_data;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_start,
                                             input bit bad_par, input bit bad_stop);
    logic par;
    par = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
    par = par ^ bad_par;
    return {~bad_stop, par, d, bad_start};
  endfunction

  // Acceptance rule restated from the frame definition, independent of the DUT.
  function automatic bit frame_good(input logic [10:0] f, input bit chk_par);
    int ones;
    ones = $countones(f[9:1]);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (!chk_par || (ones % 2 == 1));
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    model.delete();
  endtask

  task automatic send_bits(input logic [10:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 0, 10);
    wait_cycles(GAP);
  endtask

  task automatic drain();
    bit r;
    got.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.fifo_count == 0 && !bus.scan_data_valid) break;
      r = 1'($urandom_range(0, 1));
      bus.scan_data_ready = r;
      if (r && bus.scan_data_valid) got.push_back(bus.scan_data);
    end
    @(negedge clk);
    bus.scan_data_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.scan_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.scan_data_valid); end
    total++; if (bus.scan_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.scan_data); end
    total++; if (bus.fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    total++; if ({bus.frame_error, bus.timeout, bus.overflow} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses: got %b want 000", {bus.frame_error, bus.timeout, bus.overflow}); end
  endtask

  task automatic test_good_frame();
    logic [10:0] f;
    f = make_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_bits(f, 0, 9);
    @(negedge clk);
    ps2_data = f[10];
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    repeat (L + 2) @(posedge clk);
    #1;
    total++; if (bus.scan_data_valid !== 1'b0) begin bad++; $display("FAIL good_early_valid: got %b want 0", bus.scan_data_valid); end
    @(posedge clk);
    #1;
    total++; if (bus.scan_data_valid !== 1'b1) begin bad++; $display("FAIL good_valid: got %b want 1", bus.scan_data_valid); end
    total++; if (bus.scan_data !== 8'h1C) begin bad++; $display("FAIL good_data: got %h want 1c", bus.scan_data); end
    total++; if (bus.fifo_count !== 4'd1) begin bad++; $display("FAIL good_count: got %0d want 1", bus.fifo_count); end
    wait_cycles(HALF);
    ps2_clk = 1'b1;
    wait_cycles(GAP);
    bus.scan_data_ready = 1'b1;
    @(negedge clk);
    bus.scan_data_ready = 1'b0;
    total++; if (bus.scan_data_valid !== 1'b0 || bus.fifo_count !== 4'd0) begin
      bad++; $display("FAIL good_pop: got valid=%b count=%0d want 0/0", bus.scan_data_valid, bus.fifo_count); end
  endtask

  task automatic test_frame_checks();
    int fe0, qb;
    fe0 = n_ferr;
    qb  = q2.size();
    send_frame(make_frame(8'hF0, 1'b0, 1'b1, 1'b0));
    total++; if (n_ferr - fe0 !== 1) begin bad++; $display("FAIL parity_error_pulses: got %0d want 1", n_ferr - fe0); end
    total++; if (bus.fifo_count !== 4'd0) begin bad++; $display("FAIL parity_count: got %0d want 0", bus.fifo_count); end
    total++; if (q2.size() !== qb + 1 || (q2.size() > qb && q2[qb] !== 8'hF0)) begin
      bad++; $display("FAIL noparity_deliver: got %0d bytes want one byte f0", q2.size() - qb); end
    fe0 = n_ferr;
    qb  = q2.size();
    send_frame(make_frame(8'hF0, 1'b0, 1'b0, 1'b1));
    total++; if (n_ferr - fe0 !== 1) begin bad++; $display("FAIL stop_error_pulses: got %0d want 1", n_ferr - fe0); end
    total++; if (q2.size() !== qb) begin bad++; $display("FAIL noparity_stop_reject: got %0d bytes want 0", q2.size() - qb); end
    fe0 = n_ferr;
    send_frame(make_frame(8'h33, 1'b1, 1'b0, 1'b0));
    total++; if (n_ferr - fe0 !== 1 || bus.fifo_count !== 4'd0) begin
      bad++; $display("FAIL start_error: got pulses=%0d count=%0d want 1/0", n_ferr - fe0, bus.fifo_count); end
  endtask

  task automatic test_timeout();
    int t0, fe0;
    t0  = n_tout;
    fe0 = n_ferr;
    send_bits(make_frame(8'hA5, 1'b0, 1'b0, 1'b0), 0, 4);
    wait_cycles(TOUT + 50);
    total++; if (n_tout - t0 !== 1) begin bad++; $display("FAIL timeout_pulses: got %0d want 1", n_tout - t0); end
    total++; if (n_ferr !== fe0 || bus.fifo_count !== 4'd0) begin
      bad++; $display("FAIL timeout_side: got ferr=%0d count=%0d want 0/0", n_ferr - fe0, bus.fifo_count); end
    send_frame(make_frame(8'h5A, 1'b0, 1'b0, 1'b0));
    total++; if (bus.scan_data_valid !== 1'b1 || bus.scan_data !== 8'h5A) begin
      bad++; $display("FAIL after_timeout: got valid=%b data=%h want 1/5a", bus.scan_data_valid, bus.scan_data); end
    total++; if (n_tout - t0 !== 1) begin bad++; $display("FAIL timeout_spurious: got %0d want 1", n_tout - t0); end
    drain();
  endtask

  task automatic test_overflow_and_full_pushpop();
    int ov0;
    logic [10:0] f;
    ov0 = n_ovf;
    model.delete();
    for (int i = 1; i <= DEP + 1; i++) begin
      send_frame(make_frame(8'(i), 1'b0, 1'b0, 1'b0));
      if (model.size() < DEP) model.push_back(8'(i));
    end
    total++; if (bus.fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count: got %0d want 8", bus.fifo_count); end
    total++; if (n_ovf - ov0 !== 1) begin bad++; $display("FAIL ovf_pulses: got %0d want 1", n_ovf - ov0); end
    // Full FIFO: consumer pops in the CHECK cycle of a new good frame.
    ov0 = n_ovf;
    f = make_frame(8'h77, 1'b0, 1'b0, 1'b0);
    send_bits(f, 0, 9);
    @(negedge clk);
    ps2_data = f[10];
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    repeat (L + 2) @(posedge clk);
    #1;
    bus.scan_data_ready = 1'b1;
    #1;
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf: got %b want 0", bus.overflow); end
    total++; if (bus.scan_data !== model[0]) begin bad++; $display("FAIL full_pushpop_head: got %h want %h", bus.scan_data, model[0]); end
    @(posedge clk);
    #1;
    bus.scan_data_ready = 1'b0;
    void'(model.pop_front());
    model.push_back(8'h77);
    total++; if (bus.fifo_count !== 4'd8) begin bad++; $display("FAIL full_pushpop_count: got %0d want 8", bus.fifo_count); end
    wait_cycles(HALF);
    ps2_clk = 1'b1;
    wait_cycles(GAP);
    total++; if (n_ovf !== ov0) begin bad++; $display("FAIL full_pushpop_pulses: got %0d want 0", n_ovf - ov0); end
    drain();
    total++; if (got.size() !== model.size()) begin bad++; $display("FAIL drain_size: got %0d want %0d", got.size(), model.size()); end
    for (int i = 0; i < model.size(); i++) begin
      total++;
      if (i >= got.size() || got[i] !== model[i]) begin
        bad++; $display("FAIL drain_order[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, model[i]); end
    end
    model.delete();
  endtask

  task automatic test_glitch();
    int fe0, t0;
    logic [10:0] f;
    fe0 = n_ferr;
    t0  = n_tout;
    f = make_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); ps2_clk = 1'b0; wait_cycles(L - 1); ps2_clk = 1'b1; wait_cycles(10);
    end
    total++; if (bus.fifo_count !== 4'd0 || n_ferr !== fe0) begin
      bad++; $display("FAIL idle_glitch: got count=%0d ferr=%0d want 0/0", bus.fifo_count, n_ferr - fe0); end
    send_bits(f, 0, 4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); ps2_clk = 1'b0; wait_cycles(L - 1); ps2_clk = 1'b1; wait_cycles(10);
    end
    send_bits(f, 5, 10);
    wait_cycles(GAP);
    total++; if (bus.fifo_count !== 4'd1 || bus.scan_data !== 8'h3C) begin
      bad++; $display("FAIL glitch_frame: got count=%0d data=%h want 1/3c", bus.fifo_count, bus.scan_data); end
    total++; if (n_ferr !== fe0 || n_tout !== t0) begin
      bad++; $display("FAIL glitch_pulses: got ferr=%0d tout=%0d want 0/0", n_ferr - fe0, n_tout - t0); end
    drain();
  endtask

  task automatic test_reset_midframe();
    int fe0, t0;
    send_frame(make_frame(8'h66, 1'b0, 1'b0, 1'b0));
    send_bits(make_frame(8'hC3, 1'b0, 1'b0, 1'b0), 0, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if ({bus.scan_data_valid, bus.scan_data, bus.fifo_count} !== 13'd0) begin
      bad++; $display("FAIL midreset_outputs: got valid=%b data=%h count=%0d want 0", bus.scan_data_valid, bus.scan_data, bus.fifo_count); end
    reset = 1'b0;
    model.delete();
    fe0 = n_ferr;
    t0  = n_tout;
    wait_cycles(5);
    send_frame(make_frame(8'h29, 1'b0, 1'b0, 1'b0));
    total++; if (bus.fifo_count !== 4'd1 || bus.scan_data !== 8'h29) begin
      bad++; $display("FAIL post_reset_frame: got count=%0d data=%h want 1/29", bus.fifo_count, bus.scan_data); end
    total++; if (n_ferr !== fe0 || n_tout !== t0) begin
      bad++; $display("FAIL post_reset_pulses: got ferr=%0d tout=%0d want 0/0", n_ferr - fe0, n_tout - t0); end
    drain();
  endtask

  task automatic test_random();
    int fe0, ov0, n, exp_fe, exp_ov, kind;
    logic [7:0] d;
    logic [10:0] f;
    for (int round = 0; round < 4; round++) begin
      fe0 = n_ferr; ov0 = n_ovf; exp_fe = 0; exp_ov = 0;
      model.delete();
      n = $urandom_range(3, 10);
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        kind = $urandom_range(0, 5);
        f = make_frame(d, kind == 2, kind == 0, kind == 1);
        send_frame(f);
        if (!frame_good(f, 1'b1)) exp_fe++;
        else if (model.size() < DEP) model.push_back(d);
        else exp_ov++;
      end
      total++; if (bus.fifo_count !== 4'(model.size())) begin
        bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", round, bus.fifo_count, model.size()); end
      total++; if (n_ferr - fe0 !== exp_fe || n_ovf - ov0 !== exp_ov) begin
        bad++; $display("FAIL rand_pulses[%0d]: got ferr=%0d ovf=%0d want %0d/%0d", round, n_ferr - fe0, n_ovf - ov0, exp_fe, exp_ov); end
      drain();
      total++; if (got.size() !== model.size()) begin
        bad++; $display("FAIL rand_drain_size[%0d]: got %0d want %0d", round, got.size(), model.size()); end
      for (int i = 0; i < model.size() && i < got.size(); i++) begin
        total++;
        if (got[i] !== model[i]) begin bad++; $display("FAIL rand_data[%0d.%0d]: got %h want %h", round, i, got[i], model[i]); end
      end
    end
  endtask

  task automatic test_handshake();
    total++; if (stab_viol !== 0) begin bad++; $display("FAIL handshake_stable: got %0d violations want 0", stab_viol); end
  endtask

  initial begin
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    bus.scan_data_ready = 1'b0;
    wait_cycles(3);
    test_reset();
    test_good_frame();
    test_frame_checks();
    test_timeout();
    test_overflow_and_full_pushpop();
    test_glitch();
    test_reset_midframe();
    test_random();
    test_handshake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with input synchronisation, clock-line glitch filtering, full frame checking (start, odd parity, stop), inactivity timeout and an output FIFO with valid/ready handshake. It replaces the single-register scan-code capture in the keyboard path. Downstream consumers, such as the character decoder and overlay text writer, can stall without losing codes, and malformed frames are reported instead of being delivered.

## Interface
- `FILTER_LEN`, default 8: number of consecutive equal synchronised samples required before filtered `ps2_clk` changes; range 2..255.
- `TIMEOUT_CYCLES`, default 262144: `clk` cycles without a filtered falling edge that abort a partial frame.
- `FIFO_AW`, default 3: FIFO address width; depth = 2^FIFO_AW.
- `CHECK_PARITY`, default 1: 1 = odd-parity failure rejects the frame; 0 = parity bit ignored.
- `clk` input 1: system clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock line, asynchronous.
- `ps2_data` input 1: raw PS/2 data line, asynchronous.
- `scan_data` output 8: FIFO head byte (show-ahead); meaningful only while `scan_data_valid` is high.
- `scan_data_valid` output 1: FIFO not empty.
- `scan_data_ready` input 1: consumer accepts the head byte when valid && ready.
- `frame_error` output 1: one-cycle pulse when a frame is rejected for start, stop or parity failure.
- `timeout` output 1: one-cycle pulse when a partial frame is aborted.
- `overflow` output 1: one-cycle pulse when a good frame is dropped because the FIFO is full.
- `fifo_count` output FIFO_AW+1: current FIFO occupancy, 0..2^FIFO_AW.

## Operation
- **Synchronisers:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser. Reset value is 1 (idle line level).
- **Clock filter:** filtered clk (`fclk`) resets to 1. `fclk` takes the synchronised value once that value differs from `fclk` for FILTER_LEN consecutive cycles. Any mismatch-free interruption restarts the count.
- **Falling edge:** a falling edge is the cycle where `fclk` goes 1→0. The synchronised `ps2_data` is sampled in that same cycle.
- **FSM states:**
  - IDLE: bit count = 0. A falling edge stores bit 0 and moves to RECV. The frame is stored regardless of the data value; a start bit of 1 is caught in CHECK.
  - RECV: each falling edge shifts the data into an 11-bit register LSB-first and increments the bit count. When the 11th bit is stored, go to CHECK.
  - CHECK: one cycle. The frame is good if start==0, stop==1 and (CHECK_PARITY==0 or XOR of the 8 data bits and the parity bit ==1). A good frame is pushed (or dropped with `overflow` if the FIFO is full). A bad frame pulses `frame_error` and is not pushed. Always return to IDLE.
- **Timeout:**
  - The counter clears on every falling edge and in IDLE, and increments in RECV.
  - Reaching TIMEOUT_CYCLES-1 causes the following in the next cycle: return to IDLE, clear the bit count and shift register, and pulse `timeout`.
  - A falling edge in the same cycle as expiry wins; the counter clears and no timeout occurs.
- **FIFO:** circular buffer with wrap-around pointers and an occupancy counter.
  - Pop when valid && ready.
  - Push and pop in the same cycle: both happen and the count is unchanged. This includes the full case, where the push is accepted and there is no overflow.
  - Empty with push: no bypass. Data becomes visible the next cycle.
- **Reset:**
  - Clears the FSM to IDLE, the bit count, the shift register, the timer, both FIFO pointers and `fifo_count`.
  - Sets the synchronisers and `fclk` to 1.
  - All outputs go to 0: `scan_data`=0x00, `scan_data_valid`=0, `frame_error`=0, `timeout`=0, `overflow`=0, `fifo_count`=0.
  - Reset mid-frame discards the partial frame. Reset overrides every simultaneous event.

## Timing
- **Edge latency:** the raw `ps2_clk` fall appears as an `fclk` fall 2+FILTER_LEN cycles later (steady input).
- **Frame latency:** the falling edge storing the stop bit is cycle N. CHECK occurs in N+1, the FIFO write happens at the end of N+1, and `scan_data_valid` is high and `scan_data` valid in N+2.
- **Error pulses:** `frame_error` and `overflow` are high exactly in cycle N+1. `timeout` is high for exactly one cycle.
- **Pop:** after a pop at cycle M, the next entry (or `scan_data_valid`=0) is visible in M+1. `fifo_count` updates at M+1.
- **Handshake rule:** `scan_data` and `scan_data_valid` must stay stable while valid && !ready.

## Test plan
- **Good frame:** reset, then frame 0x1C (start 0, data LSB-first, parity 0, stop 1) at 12.5 kHz PS/2 clock with a 50 MHz `clk` → `scan_data`=0x1C and `scan_data_valid`=1 two cycles after the stop-bit `fclk` fall. Ready pulse → `scan_data_valid`=0 and `fifo_count`=0.
- **Frame checks:** frame 0xF0 with parity forced to 1 → `frame_error` pulses once and `fifo_count` stays 0. Repeat with CHECK_PARITY=0 → 0xF0 is delivered. Repeat with stop=0 → `frame_error` pulses.
- **Timeout:** send 5 bits then hold `ps2_clk` high for > TIMEOUT_CYCLES → `timeout` pulses once. A following good frame 0x5A is then delivered correctly.
- **Overflow:** with `scan_data_ready`=0, send 2^FIFO_AW+1 good frames (0x01..0x09 for depth 8) → `fifo_count`=8, `overflow` pulses on the 9th, and draining yields 0x01..0x08 in order.
- **Full push/pop:** with the FIFO full, assert ready in the CHECK cycle of a new frame → no overflow and `fifo_count` stays at full.
- **Glitch and reset:** apply 0-pulses on `ps2_clk` of FILTER_LEN-1 cycles → no edge and no state change. Assert `reset` after 6 bits of a frame → all outputs 0, and a subsequent full frame 0x29 decodes correctly.
